// File: rtl/bmi_pkg.sv
// Shared types and constants for the BMI unit: FSM states, category codes,
// default thresholds and the numerator width helper.
package bmi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CAT_UNDER  = 2'd0;
  localparam logic [1:0] CAT_NORMAL = 2'd1;
  localparam logic [1:0] CAT_OVER   = 2'd2;
  localparam logic [1:0] CAT_OBESE  = 2'd3;

  localparam int T1_X10_DEF = 185;
  localparam int T2_X10_DEF = 250;
  localparam int T3_X10_DEF = 300;

  // SCALE is limited to 14 bits, so weight*SCALE fits WW+14 bits before the
  // FRAC-bit left shift.
  function automatic int num_width(input int ww, input int frac);
    return ww + 14 + frac;
  endfunction

endpackage

// File: rtl/bmi_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// The caller guarantees num < den<<N so the quotient fits in N bits.
// o_done is high during the final iteration and o_quot then carries the
// complete quotient, letting the caller register it on that same edge.
module bmi_divider
  import bmi_pkg::*;
#(
  parameter int NW = 24,
  parameter int DW = 16,
  parameter int N  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [NW-1:0] i_num,
  input  logic [DW-1:0] i_den,
  output logic          o_done,
  output logic [N-1:0]  o_quot
);

  localparam int XW = (NW > DW + N) ? NW : DW + N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [XW-1:0] r_rem;
  logic [DW-1:0] r_den;
  logic [N-1:0]  r_q;
  logic [IW-1:0] r_idx;
  logic          r_busy;

  logic [XW-1:0] w_den_sh;
  logic [XW-1:0] w_rem_next;
  logic [N-1:0]  w_q_next;
  logic          w_ge;

  // Trial subtraction of the shifted divisor for the current bit position.
  always_comb begin
    w_den_sh   = XW'(r_den) << r_idx;
    w_ge       = (r_rem >= w_den_sh);
    w_rem_next = w_ge ? (r_rem - w_den_sh) : r_rem;
    w_q_next   = w_ge ? (r_q | (N'(1) << r_idx)) : r_q;
  end

  assign o_done = r_busy && (r_idx == '0);
  assign o_quot = w_q_next;

  // Iteration state: load on start, then step the bit index down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_idx  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= XW'(i_num);
      r_den  <= i_den;
      r_q    <= '0;
      r_idx  <= IW'(N - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      if (r_idx == '0) r_busy <= 1'b0;
      else             r_idx  <= r_idx - IW'(1);
    end
  end

endmodule

// File: rtl/bmi_seq.sv
// Sequential BMI unit: handshake FSM, numerator/denominator formation,
// zero/saturation pre-checks, multi-cycle divide and category decode.
module bmi_seq
  import bmi_pkg::*;
#(
  parameter int HW     = 8,
  parameter int WW     = 8,
  parameter int SCALE  = 10000,
  parameter int QW     = 8,
  parameter int FRAC   = 2,
  parameter int T1_X10 = T1_X10_DEF,
  parameter int T2_X10 = T2_X10_DEF,
  parameter int T3_X10 = T3_X10_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HW-1:0]        height,
  input  logic [WW-1:0]        weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QW+FRAC-1:0]   bmi,
  output logic [1:0]           category,
  output logic                 saturated,
  output logic                 div_zero
);

  localparam int N  = QW + FRAC;
  localparam int NW = num_width(WW, FRAC);
  localparam int DW = 2 * HW;
  localparam int CW = (NW > DW + N) ? NW : DW + N;

  localparam int unsigned TH1 = T1_X10 << FRAC;
  localparam int unsigned TH2 = T2_X10 << FRAC;
  localparam int unsigned TH3 = T3_X10 << FRAC;

  state_t r_state;
  state_t w_state_next;

  logic [HW-1:0] r_h;
  logic [WW-1:0] r_w;

  logic [NW-1:0] w_num;
  logic [DW-1:0] w_den;
  logic          w_den_zero;
  logic          w_sat;
  logic          w_start;
  logic          w_div_done;
  logic [N-1:0]  w_quot;

  // Threshold comparison done on bmi*10 against thresholds scaled by 2^FRAC,
  // which avoids any fractional arithmetic.
  function automatic logic [1:0] cat_of(input logic [N-1:0] b);
    int unsigned b10;
    b10 = 32'(b) * 32'd10;
    if      (b10 < TH1) return CAT_UNDER;
    else if (b10 < TH2) return CAT_NORMAL;
    else if (b10 < TH3) return CAT_OVER;
    else                return CAT_OBESE;
  endfunction

  // Operand formation and pre-checks from the captured inputs.
  always_comb begin
    w_num      = (NW'(r_w) * NW'(SCALE)) << FRAC;
    w_den      = DW'(r_h) * DW'(r_h);
    w_den_zero = (w_den == '0);
    w_sat      = (CW'(w_num) >= (CW'(w_den) << N));
  end

  bmi_divider #(
    .NW (NW),
    .DW (DW),
    .N  (N)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and state-decoded handshake signals.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_den_zero || w_sat) begin
          w_state_next = S_DONE;
        end else begin
          w_start      = 1'b1;
          w_state_next = S_DIV;
        end
      end
      S_DIV: begin
        if (w_div_done) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Input capture and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h       <= '0;
      r_w       <= '0;
      bmi       <= '0;
      category  <= CAT_UNDER;
      saturated <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_h       <= height;
            r_w       <= weight;
            saturated <= 1'b0;
            div_zero  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_den_zero) begin
            bmi      <= '1;
            div_zero <= 1'b1;
            category <= CAT_OBESE;
          end else if (w_sat) begin
            bmi       <= '1;
            saturated <= 1'b1;
            category  <= CAT_OBESE;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            bmi      <= w_quot;
            category <= cat_of(w_quot);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmi_seq.sv
// Directed testbench for bmi_seq with default parameters.
module tb_bmi_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] height;
  logic [7:0] weight;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] bmi;
  logic [1:0] category;
  logic       saturated;
  logic       div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bmi_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .height    (height),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bmi       (bmi),
    .category  (category),
    .saturated (saturated),
    .div_zero  (div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and count cycles until out_valid, bounded.
  task automatic run_req(input logic [7:0] h, input logic [7:0] w, output int lat);
    height   = h;
    weight   = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    height   = 8'hA5;
    weight   = 8'h5A;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (bmi !== 10'd0 || category !== 2'd0) begin bad++; $display("FAIL reset_data got=%0d/%0d exp=0/0", bmi, category); end
    total++; if (saturated !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", saturated, div_zero); end
  endtask

  task automatic test_normal();
    int lat;
    run_req(8'd175, 8'd70, lat);
    total++; if (lat !== 12) begin bad++; $display("FAIL normal_latency got=%0d exp=12", lat); end
    total++; if (bmi !== 10'd91) begin bad++; $display("FAIL normal_bmi got=%0d exp=91", bmi); end
    total++; if (category !== 2'd1) begin bad++; $display("FAIL normal_cat got=%0d exp=1", category); end
    total++; if (saturated !== 1'b0 || div_zero !== 1'b0) begin bad++; $display("FAIL normal_flags got=%b%b exp=00", saturated, div_zero); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL normal_in_ready_done got=%b exp=0", in_ready); end
    accept();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL normal_accept got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_patterns();
    int lat;
    run_req(8'd160, 8'd90, lat);
    total++; if (lat !== 12) begin bad++; $display("FAIL obese_latency got=%0d exp=12", lat); end
    total++; if (bmi !== 10'd140 || category !== 2'd3) begin bad++; $display("FAIL obese_result got=%0d/%0d exp=140/3", bmi, category); end
    accept();
    run_req(8'd180, 8'd50, lat);
    total++; if (lat !== 12) begin bad++; $display("FAIL under_latency got=%0d exp=12", lat); end
    total++; if (bmi !== 10'd61 || category !== 2'd0) begin bad++; $display("FAIL under_result got=%0d/%0d exp=61/0", bmi, category); end
    accept();
    // 183 cm / 90 kg: 3600000/33489 = 107.49 -> 107 (26.75), overweight
    run_req(8'd183, 8'd90, lat);
    total++; if (bmi !== 10'd107 || category !== 2'd2) begin bad++; $display("FAIL over_result got=%0d/%0d exp=107/2", bmi, category); end
    accept();
  endtask

  task automatic test_div_zero();
    int lat;
    run_req(8'd0, 8'd80, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    total++; if (bmi !== 10'd1023 || category !== 2'd3) begin bad++; $display("FAIL dz_result got=%0d/%0d exp=1023/3", bmi, category); end
    total++; if (div_zero !== 1'b1 || saturated !== 1'b0) begin bad++; $display("FAIL dz_flags got=%b%b exp=01", saturated, div_zero); end
    accept();
  endtask

  task automatic test_saturate();
    int lat;
    run_req(8'd10, 8'd255, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sat_latency got=%0d exp=2", lat); end
    total++; if (bmi !== 10'd1023 || category !== 2'd3) begin bad++; $display("FAIL sat_result got=%0d/%0d exp=1023/3", bmi, category); end
    total++; if (saturated !== 1'b1 || div_zero !== 1'b0) begin bad++; $display("FAIL sat_flags got=%b%b exp=10", saturated, div_zero); end
    accept();
  endtask

  task automatic test_backpressure();
    int lat;
    int errs;
    run_req(8'd160, 8'd90, lat);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      height   = 8'd50;
      weight   = 8'd200;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bmi !== 10'd140 || category !== 2'd3) errs++;
    end
    in_valid = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles exp=0 (last bmi=%0d)", errs, bmi); end
    accept();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_accept got=%b%b exp=01", out_valid, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_no_capture got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    height   = 8'd175;
    weight   = 8'd70;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset_hs got=%b%b exp=10", in_ready, out_valid); end
    total++; if (bmi !== 10'd0 || category !== 2'd0 || saturated !== 1'b0 || div_zero !== 1'b0) begin
      bad++; $display("FAIL midreset_data got=%0d/%0d/%b%b exp=0/0/00", bmi, category, saturated, div_zero); end
    run_req(8'd175, 8'd70, lat);
    total++; if (lat !== 12 || bmi !== 10'd91 || category !== 2'd1) begin
      bad++; $display("FAIL midreset_rerun got=lat%0d %0d/%0d exp=lat12 91/1", lat, bmi, category); end
    accept();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_req(8'd0, 8'd10, lat);
    accept();
    run_req(8'd180, 8'd50, lat);
    total++; if (bmi !== 10'd61 || div_zero !== 1'b0 || saturated !== 1'b0) begin
      bad++; $display("FAIL b2b_flags_cleared got=%0d/%b%b exp=61/00", bmi, saturated, div_zero); end
    accept();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    height    = '0;
    weight    = '0;
    test_reset();
    test_normal();
    test_patterns();
    test_div_zero();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
